// File: rtl/weight_row_mac.sv
// weight_row_mac: one row of a Q8.8 dot product. The block takes N_TAPS pixels
// over a valid/ready stream and multiplies each by a weight read from an
// external BRAM. It adds the bias and presents a saturated Q8.8 result together
// with the raw accumulator.
// Latency: the result registers one edge after the last pixel accept.
// Backpressure: X_READY drops once all taps are accepted. In DONE the result
// holds until Y_READY is seen.
//
// Ports:
//   CLK, RST_N          clock, async active-low reset
//   START, BIAS         begin a row; BIAS (Q8.8) is sampled with START in IDLE
//   X_DATA/VALID/READY  pixel stream (Q8.8)
//   BRAM_*              weight memory port (read-only use); BRAM_DO is updated
//                       by the memory on the falling edge of CLK
//   Y_DATA/ACC          saturated Q8.8 result / full-precision accumulator
//   Y_VALID/READY       result handshake
//   BUSY                high whenever not IDLE
// N_TAPS must not exceed 32 so that the tap index fits BRAM_ADDR.

module weight_row_mac #(
  parameter int N_TAPS = 28,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [15:0]      BIAS,
  input  logic [15:0]      X_DATA,
  input  logic             X_VALID,
  output logic             X_READY,
  output logic [4:0]       BRAM_ADDR,
  output logic             BRAM_EN,
  output logic             BRAM_WE,
  output logic [15:0]      BRAM_DI,
  input  logic [15:0]      BRAM_DO,
  output logic [15:0]      Y_DATA,
  output logic [ACC_W-1:0] Y_ACC,
  output logic             Y_VALID,
  input  logic             Y_READY,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [5:0]             C_NTAPS = 6'(N_TAPS);
  localparam logic signed [ACC_W-1:0] C_YMAX = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] C_YMIN = ACC_W'(-32'sd32768);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [5:0]              r_cnt;
  logic                    r_mac_v;
  logic signed [15:0]      r_x;
  logic signed [15:0]      r_w;
  logic signed [ACC_W-1:0] r_acc;
  logic [15:0]             r_y_dat;
  logic [ACC_W-1:0]        r_y_acc;
  logic                    r_y_vld;

  logic                    w_accept;
  logic                    w_last;
  logic signed [31:0]      w_prod;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_shift;
  logic [15:0]             w_sat;

  assign X_READY   = (r_state == S_RUN) && (r_cnt < C_NTAPS);
  assign w_accept  = X_VALID && X_READY;
  assign BRAM_ADDR = r_cnt[4:0];
  assign BRAM_EN   = w_accept;
  assign BRAM_WE   = 1'b0;
  assign BRAM_DI   = 16'h0000;
  assign BUSY      = (r_state != S_IDLE);
  assign Y_DATA    = r_y_dat;
  assign Y_ACC     = r_y_acc;
  assign Y_VALID   = r_y_vld;

  // The MAC pending now is the final tap once every tap has been accepted.
  assign w_last     = r_mac_v && (r_cnt == C_NTAPS);
  assign w_prod     = r_x * r_w;
  assign w_bias_ext = ACC_W'($signed(BIAS)) <<< FRAC;
  assign w_sum      = r_acc + ACC_W'(w_prod);
  assign w_shift    = w_sum >>> FRAC;

  always_comb begin
    w_sat = w_shift[15:0];
    if (w_shift > C_YMAX) begin
      w_sat = 16'h7FFF;
    end else if (w_shift < C_YMIN) begin
      w_sat = 16'h8000;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (START)   w_state_nxt = S_RUN;
      S_RUN:   if (w_last)  w_state_nxt = S_DONE;
      S_DONE:  if (Y_READY) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt   <= '0;
      r_mac_v <= 1'b0;
      r_x     <= '0;
      r_w     <= '0;
      r_acc   <= '0;
      r_y_dat <= '0;
      r_y_acc <= '0;
      r_y_vld <= 1'b0;
    end else begin
      // No accept is possible outside RUN, so this also clears mac_v on START.
      r_mac_v <= w_accept;

      if (r_state == S_IDLE && START) begin
        r_acc <= w_bias_ext;
        r_cnt <= '0;
      end

      // The memory already presents the weight for this address on the falling
      // edge before the accept. It is captured here with the pixel, because a
      // back-to-back accept would overwrite BRAM_DO before the MAC edge.
      if (w_accept) begin
        r_x   <= $signed(X_DATA);
        r_w   <= $signed(BRAM_DO);
        r_cnt <= r_cnt + 6'd1;
      end

      if (r_state == S_RUN && r_mac_v) begin
        r_acc <= w_sum;
      end

      if (r_state == S_RUN && w_last) begin
        r_y_acc <= w_sum;
        r_y_dat <= w_sat;
        r_y_vld <= 1'b1;
      end else if (r_state == S_DONE && Y_READY) begin
        r_y_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_weight_row_mac.sv
module tb_weight_row_mac;

  localparam int NT = 28;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic [15:0] BIAS = 16'h0;
  logic [15:0] X_DATA = 16'h0;
  logic        X_VALID = 1'b0;
  logic        X_READY;
  logic [4:0]  BRAM_ADDR;
  logic        BRAM_EN;
  logic        BRAM_WE;
  logic [15:0] BRAM_DI;
  logic [15:0] BRAM_DO = 16'h0;
  logic [15:0] Y_DATA;
  logic [39:0] Y_ACC;
  logic        Y_VALID;
  logic        Y_READY = 1'b0;
  logic        BUSY;

  int checks = 0;
  int failures = 0;

  weight_row_mac #(.N_TAPS(NT), .FRAC(8), .ACC_W(40)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .BIAS(BIAS),
    .X_DATA(X_DATA), .X_VALID(X_VALID), .X_READY(X_READY),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE),
    .BRAM_DI(BRAM_DI), .BRAM_DO(BRAM_DO),
    .Y_DATA(Y_DATA), .Y_ACC(Y_ACC), .Y_VALID(Y_VALID), .Y_READY(Y_READY),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Weight memory: registered read on the falling edge.
  logic [15:0] mem [32];
  always @(negedge CLK) if (BRAM_EN) BRAM_DO <= mem[BRAM_ADDR];

  // Port monitor: every enabled read address, and any write activity.
  int en_total = 0;
  int addr_log[$];
  int we_bad = 0;
  always @(negedge CLK) begin
    if (BRAM_EN === 1'b1) begin
      en_total++;
      addr_log.push_back(int'(BRAM_ADDR));
    end
    if (BRAM_WE !== 1'b0 || BRAM_DI !== 16'h0) we_bad++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic fill_mem(input logic [15:0] w);
    for (int i = 0; i < 32; i++) mem[i] = (i < NT) ? w : 16'h7FFF;
  endtask

  // Drives one row and reports what it observed. It makes no comparisons.
  task automatic run_row(input logic [15:0] bias, input logic [15:0] px,
                         input bit gaps, input int hold, input bit poke,
                         output logic [15:0] yd, output logic [39:0] ya,
                         output int lat, output int en_n, output int addr_bad,
                         output bit stable, output bit busy_ok,
                         output bit idle_after, output bit timeout);
    int sent, n, start_en, start_idx;
    bit acc;
    timeout = 0; stable = 1; busy_ok = 1; addr_bad = 0;
    start_en = en_total; start_idx = addr_log.size();
    @(posedge CLK); #1; START = 1'b1; BIAS = bias;
    @(posedge CLK); #1; START = 1'b0; BIAS = 16'h0;
    sent = 0; n = 0;
    while (sent < NT && n < 2000) begin
      X_DATA  = px;
      X_VALID = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      START   = poke && (n % 3 == 0);
      @(negedge CLK);
      acc = X_VALID && X_READY;
      if (BUSY !== 1'b1) busy_ok = 0;
      @(posedge CLK); #1;
      if (acc) sent++;
      n++;
    end
    X_VALID = 1'b0; START = 1'b0;
    if (sent < NT) timeout = 1;
    lat = 0;
    while (Y_VALID !== 1'b1 && lat < 50) begin
      START = poke;
      @(posedge CLK); #1;
      lat++;
    end
    if (Y_VALID !== 1'b1) timeout = 1;
    yd = Y_DATA; ya = Y_ACC;
    repeat (hold) begin
      START = poke;
      if (BUSY !== 1'b1) busy_ok = 0;
      @(posedge CLK); #1;
      if (Y_VALID !== 1'b1 || Y_DATA !== yd || Y_ACC !== ya) stable = 0;
    end
    // START is also high on the DONE->IDLE edge when poke is set.
    Y_READY = 1'b1; START = poke;
    @(posedge CLK); #1;
    Y_READY = 1'b0; START = 1'b0;
    idle_after = (BUSY === 1'b0 && Y_VALID === 1'b0 && Y_DATA === yd && Y_ACC === ya);
    en_n = en_total - start_en;
    for (int i = 0; i < en_n; i++) if (addr_log[start_idx + i] != i) addr_bad++;
  endtask

  task automatic test_reset;
    RST_N = 1'b0; X_VALID = 1'b1; START = 1'b0;
    #1;
    checks++; if (X_READY !== 1'b0) begin failures++; $display("FAIL reset_x_ready got=%b exp=0", X_READY); end
    checks++; if (BRAM_EN !== 1'b0) begin failures++; $display("FAIL reset_bram_en got=%b exp=0", BRAM_EN); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    checks++; if (BRAM_ADDR !== 5'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", BRAM_ADDR); end
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (Y_VALID !== 1'b0) begin failures++; $display("FAIL reset_y_valid got=%b exp=0", Y_VALID); end
    checks++; if (Y_DATA !== 16'h0) begin failures++; $display("FAIL reset_y_data got=%h exp=0000", Y_DATA); end
    checks++; if (Y_ACC !== 40'h0) begin failures++; $display("FAIL reset_y_acc got=%h exp=0", Y_ACC); end
    RST_N = 1'b1;
    @(posedge CLK); #1;
    checks++; if (X_READY !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL idle_no_ready got ready=%b busy=%b exp 0/0", X_READY, BUSY); end
    X_VALID = 1'b0;
  endtask

  task automatic test_unit_row;
    logic [15:0] yd; logic [39:0] ya; int lat, en_n, ab; bit st, bo, ia, to;
    fill_mem(16'h0100);
    run_row(16'h0000, 16'h0100, 0, 0, 0, yd, ya, lat, en_n, ab, st, bo, ia, to);
    checks++; if (to) begin failures++; $display("FAIL unit_timeout got=1 exp=0"); end
    checks++; if (yd !== 16'h1C00) begin failures++; $display("FAIL unit_y_data got=%h exp=1c00", yd); end
    checks++; if (ya !== 40'd1835008) begin failures++; $display("FAIL unit_y_acc got=%0d exp=1835008", ya); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL unit_latency got=%0d exp=1", lat); end
    checks++; if (en_n !== NT || ab !== 0) begin failures++; $display("FAIL unit_bram got en=%0d badaddr=%0d exp 28/0", en_n, ab); end
    checks++; if (!ia) begin failures++; $display("FAIL unit_release got idle=%b exp=1", ia); end
  endtask

  task automatic test_bias_sign;
    logic [15:0] yd; logic [39:0] ya; int lat, en_n, ab; bit st, bo, ia, to;
    fill_mem(16'hFF00);
    run_row(16'h0200, 16'h0080, 0, 0, 0, yd, ya, lat, en_n, ab, st, bo, ia, to);
    checks++; if (yd !== 16'hF400) begin failures++; $display("FAIL bias_y_data got=%h exp=f400", yd); end
    checks++; if (ya !== 40'hFF_FFF4_0000) begin failures++; $display("FAIL bias_y_acc got=%h exp=fffff40000", ya); end
  endtask

  task automatic test_ramp;
    logic [15:0] yd; logic [39:0] ya; int lat, en_n, ab; bit st, bo, ia, to;
    fill_mem(16'h0);
    for (int i = 0; i < NT; i++) mem[i] = 16'(i * 16);
    // sum(i/16 * 1.0) for i=0..27 = 23.625 -> 0x17A0
    run_row(16'h0000, 16'h0100, 0, 0, 0, yd, ya, lat, en_n, ab, st, bo, ia, to);
    checks++; if (yd !== 16'h17A0) begin failures++; $display("FAIL ramp_y_data got=%h exp=17a0", yd); end
    checks++; if (ya !== 40'd1548288) begin failures++; $display("FAIL ramp_y_acc got=%0d exp=1548288", ya); end
  endtask

  task automatic test_saturation;
    logic [15:0] yd; logic [39:0] ya; int lat, en_n, ab; bit st, bo, ia, to;
    fill_mem(16'h7FFF);
    run_row(16'h0000, 16'h7FFF, 0, 0, 0, yd, ya, lat, en_n, ab, st, bo, ia, to);
    checks++; if (yd !== 16'h7FFF) begin failures++; $display("FAIL sat_pos_y_data got=%h exp=7fff", yd); end
    checks++; if (ya !== 40'd30062936092) begin failures++; $display("FAIL sat_pos_y_acc got=%0d exp=30062936092", ya); end
    run_row(16'h0000, 16'h8001, 0, 0, 0, yd, ya, lat, en_n, ab, st, bo, ia, to);
    checks++; if (yd !== 16'h8000) begin failures++; $display("FAIL sat_neg_y_data got=%h exp=8000", yd); end
    checks++; if (ya !== -40'sd30062936092) begin failures++; $display("FAIL sat_neg_y_acc got=%h exp=-30062936092", ya); end
  endtask

  task automatic test_stall_backpressure;
    logic [15:0] yd; logic [39:0] ya; int lat, en_n, ab; bit st, bo, ia, to;
    fill_mem(16'h0100);
    run_row(16'h0000, 16'h0100, 1, 10, 0, yd, ya, lat, en_n, ab, st, bo, ia, to);
    checks++; if (to) begin failures++; $display("FAIL stall_timeout got=1 exp=0"); end
    checks++; if (yd !== 16'h1C00 || ya !== 40'd1835008) begin failures++; $display("FAIL stall_result got=%h/%0d exp=1c00/1835008", yd, ya); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL stall_latency got=%0d exp=1", lat); end
    checks++; if (!st) begin failures++; $display("FAIL stall_hold_stable got=0 exp=1"); end
    checks++; if (en_n !== NT) begin failures++; $display("FAIL stall_en_count got=%0d exp=28", en_n); end
    checks++; if (ab !== 0) begin failures++; $display("FAIL stall_addr_order got=%0d bad exp=0", ab); end
    checks++; if (!ia) begin failures++; $display("FAIL stall_release got idle=%b exp=1", ia); end
  endtask

  task automatic test_reset_mid_row;
    logic [15:0] yd; logic [39:0] ya; int lat, en_n, ab; bit st, bo, ia, to;
    bit seen;
    fill_mem(16'h0100);
    @(posedge CLK); #1; START = 1'b1; BIAS = 16'h0100;
    @(posedge CLK); #1; START = 1'b0; X_DATA = 16'h0100; X_VALID = 1'b1;
    repeat (13) @(posedge CLK);
    #1;
    checks++; if (BRAM_ADDR !== 5'd13) begin failures++; $display("FAIL abort_addr got=%0d exp=13", BRAM_ADDR); end
    RST_N = 1'b0;
    #1;
    checks++; if (X_READY !== 1'b0 || BRAM_EN !== 1'b0) begin failures++; $display("FAIL abort_rst_outputs got ready=%b en=%b exp 0/0", X_READY, BRAM_EN); end
    checks++; if (BUSY !== 1'b0 || BRAM_ADDR !== 5'd0) begin failures++; $display("FAIL abort_rst_state got busy=%b addr=%0d exp 0/0", BUSY, BRAM_ADDR); end
    @(negedge CLK);
    checks++; if (X_READY !== 1'b0 || BRAM_EN !== 1'b0) begin failures++; $display("FAIL abort_rst_hold got ready=%b en=%b exp 0/0", X_READY, BRAM_EN); end
    @(posedge CLK); #1;
    RST_N = 1'b1; X_VALID = 1'b0;
    seen = 0;
    repeat (10) begin @(posedge CLK); #1; if (Y_VALID !== 1'b0) seen = 1; end
    checks++; if (seen) begin failures++; $display("FAIL abort_no_y_valid got=1 exp=0"); end
    // New row with bias 1.0: 29.0 -> 0x1D00
    run_row(16'h0100, 16'h0100, 0, 0, 0, yd, ya, lat, en_n, ab, st, bo, ia, to);
    checks++; if (yd !== 16'h1D00 || ya !== 40'd1900544) begin failures++; $display("FAIL abort_new_row got=%h/%0d exp=1d00/1900544", yd, ya); end
    checks++; if (en_n !== NT || ab !== 0) begin failures++; $display("FAIL abort_new_bram got en=%0d badaddr=%0d exp 28/0", en_n, ab); end
  endtask

  task automatic test_start_ignored;
    logic [15:0] yd; logic [39:0] ya; int lat, en_n, ab; bit st, bo, ia, to;
    fill_mem(16'h0100);
    run_row(16'h0000, 16'h0100, 1, 3, 1, yd, ya, lat, en_n, ab, st, bo, ia, to);
    checks++; if (yd !== 16'h1C00 || ya !== 40'd1835008) begin failures++; $display("FAIL start_ign_result got=%h/%0d exp=1c00/1835008", yd, ya); end
    checks++; if (!bo) begin failures++; $display("FAIL start_ign_busy got=0 exp=1"); end
    checks++; if (en_n !== NT) begin failures++; $display("FAIL start_ign_en_count got=%0d exp=28", en_n); end
    checks++; if (!ia) begin failures++; $display("FAIL start_ign_on_release got idle=%b busy=%b exp idle", ia, BUSY); end
    checks++; if (we_bad !== 0) begin failures++; $display("FAIL bram_we_di got=%0d cycles nonzero exp=0", we_bad); end
  endtask

  initial begin
    test_reset();
    test_unit_row();
    test_bias_sign();
    test_ramp();
    test_saturation();
    test_stall_backpressure();
    test_reset_mid_row();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
